// File: rtl/fsm_code_logger.sv
// Run-length logger for a 2-bit FSM output code.
// Each run of constant code becomes a {code, length} record in a small first-word-fall-through FIFO.
module fsm_code_logger #(
  parameter int unsigned RUN_W = 6,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [1:0]               y_in,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [1:0]               out_code,
  output logic [RUN_W-1:0]         out_run,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [RUN_W-1:0] RUN_MAX = '1;

  typedef struct packed {
    logic [1:0]       code;
    logic [RUN_W-1:0] run;
  } rec_t;

  logic             primed;
  logic [1:0]       prev;
  logic [RUN_W-1:0] run;
  rec_t             mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  logic boundary_c, push_c, pop_c, full_c, write_c;
  rec_t head_c;

  // Segment boundary detection and FIFO handshake decode
  always_comb begin
    boundary_c = flush || (y_in != prev);
    push_c     = primed && boundary_c;
    pop_c      = (fifo_count != '0) && out_ready;
    full_c     = (fifo_count == CW'(DEPTH));
    write_c    = push_c && (!full_c || pop_c);
    head_c     = mem[rd_ptr];
  end

  assign out_valid = (fifo_count != '0);
  assign out_code  = out_valid ? head_c.code : 2'b00;
  assign out_run   = out_valid ? head_c.run  : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      primed     <= 1'b0;
      prev       <= 2'b00;
      run        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      // Run tracking: first edge after reset only primes
      if (!primed) begin
        prev   <= y_in;
        run    <= RUN_W'(1);
        primed <= 1'b1;
      end else if (boundary_c) begin
        prev <= y_in;
        run  <= RUN_W'(1);
      end else if (run != RUN_MAX) begin
        run <= run + RUN_W'(1);
      end

      if (write_c) begin
        mem[wr_ptr] <= '{code: prev, run: run};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_c) rd_ptr <= rd_ptr + AW'(1);

      case ({write_c, pop_c})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase

      // Sticky drop flag: push into a full FIFO with nothing leaving
      if (push_c && full_c && !pop_c) overflow <= 1'b1;
    end
  end

endmodule
